// File: rtl/gelato_types.sv
// ============================================================================
// Module      : gelato_types
// Description : Shared instruction type for decoder, warp buffers and issuer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

package gelato_types;

    typedef struct packed {
        logic [7:0] opcode;
        logic [5:0] rd;
        logic [5:0] rs1;
        logic [5:0] rs2;
        logic [5:0] imm;
    } inst_t;

endpackage

`default_nettype wire

// File: rtl/gelato_rr_arbiter.sv
// ============================================================================
// Module      : gelato_rr_arbiter
// Description : Combinational round-robin arbiter; first request at/after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gelato_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic [N-1:0]         grant_onehot
);

    localparam int W = $clog2(N);

    logic [W-1:0] w_idx;

    // N is a power of two, so the W-bit add wraps from N-1 back to 0.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_idx       = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = ptr + i[W-1:0];
            if (!grant_valid && req[w_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = w_idx;
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (grant_valid) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gelato_warp_inst_issuer.sv
// ============================================================================
// Module      : gelato_warp_inst_issuer
// Description : Round-robin pop of per-warp instruction buffers into a
//               registered valid/ready issue slot. Optional stall counter
//               enabled by GELATO_ISSUE_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gelato_warp_inst_issuer
    import gelato_types::*;
#(
    parameter int NUM_WARPS     = `NUM_WARPS,
    parameter int WARP_ID_WIDTH = $clog2(NUM_WARPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic [NUM_WARPS-1:0]     buf_empty,
    input  inst_t                    buf_tail_data [NUM_WARPS],
    output logic [NUM_WARPS-1:0]     buf_pop_enabled,
    output logic                     issue_valid,
    output inst_t                    issue_inst,
    output logic [WARP_ID_WIDTH-1:0] issue_warp_id,
    input  logic                     issue_ready,
    input  logic [NUM_WARPS-1:0]     warp_mask
`ifdef GELATO_ISSUE_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    logic [WARP_ID_WIDTH-1:0] rr_ptr;
    logic [NUM_WARPS-1:0]     w_elig;
    logic [NUM_WARPS-1:0]     w_req;
    logic                     w_slot_free;
    logic                     w_grant_valid;
    logic [WARP_ID_WIDTH-1:0] w_grant_idx;
    logic [NUM_WARPS-1:0]     w_grant_onehot;

    assign w_elig      = ~buf_empty & warp_mask;
    assign w_slot_free = !issue_valid || issue_ready;
    assign w_req       = (rdy && w_slot_free) ? w_elig : '0;

    gelato_rr_arbiter #(
        .N (NUM_WARPS)
    ) u_arb (
        .req          (w_req),
        .ptr          (rr_ptr),
        .grant_valid  (w_grant_valid),
        .grant_idx    (w_grant_idx),
        .grant_onehot (w_grant_onehot)
    );

    // The strobe must be silent while reset is held, even with full buffers.
    assign buf_pop_enabled = rst_n ? w_grant_onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid   <= 1'b0;
            issue_inst    <= '0;
            issue_warp_id <= '0;
            rr_ptr        <= '0;
        end else if (rdy) begin
            if (w_grant_valid) begin
                issue_valid   <= 1'b1;
                issue_inst    <= buf_tail_data[w_grant_idx];
                issue_warp_id <= w_grant_idx;
                rr_ptr        <= w_grant_idx + 1'b1;
            end else if (issue_valid && issue_ready) begin
                issue_valid <= 1'b0;
            end
        end
    end

`ifdef GELATO_ISSUE_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (rdy && issue_valid && !issue_ready &&
                     (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gelato_warp_inst_issuer.sv
// ============================================================================
// Module      : tb_gelato_warp_inst_issuer
// Description : Directed self-checking bench with simple per-warp FIFO models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gelato_warp_inst_issuer;
    import gelato_types::*;

    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdy;
    logic [NW-1:0] buf_empty;
    inst_t         buf_tail_data [NW];
    logic [NW-1:0] buf_pop_enabled;
    logic          issue_valid;
    inst_t         issue_inst;
    logic [1:0]    issue_warp_id;
    logic          issue_ready;
    logic [NW-1:0] warp_mask;
`ifdef GELATO_ISSUE_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    inst_t      mem [NW][16];
    logic [3:0] wr  [NW];
    logic [3:0] rd  [NW];

    always #5 clk = ~clk;

    gelato_warp_inst_issuer #(.NUM_WARPS(NW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdy             (rdy),
        .buf_empty       (buf_empty),
        .buf_tail_data   (buf_tail_data),
        .buf_pop_enabled (buf_pop_enabled),
        .issue_valid     (issue_valid),
        .issue_inst      (issue_inst),
        .issue_warp_id   (issue_warp_id),
        .issue_ready     (issue_ready),
        .warp_mask       (warp_mask)
`ifdef GELATO_ISSUE_STALL_CNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    always_comb begin
        for (int w = 0; w < NW; w++) begin
            buf_empty[w]     = (wr[w] == rd[w]);
            buf_tail_data[w] = mem[w][rd[w]];
        end
    end

    // Buffer model: dequeue on strobe, flush on a clock edge seen in reset.
    always @(posedge clk) begin
        for (int w = 0; w < NW; w++) begin
            if (!rst_n)                  rd[w] <= wr[w];
            else if (buf_pop_enabled[w]) rd[w] <= rd[w] + 4'd1;
        end
    end

    function automatic inst_t mk(input int w, input int n);
        logic [31:0] v;
        v = {8'hA0 + 8'(w), 8'h5A, 16'(n)};
        return inst_t'(v);
    endfunction

    task automatic push(input int w, input int n);
        mem[w][wr[w]] = mk(w, n);
        wr[w] = wr[w] + 4'd1;
    endtask

    task automatic test_reset();
        for (int w = 0; w < NW; w++) wr[w] = 4'd0;
        rst_n = 1'b0; rdy = 1'b1; issue_ready = 1'b1; warp_mask = 4'hF;
        #12;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", issue_valid); end
        n_checks++; if (issue_inst !== inst_t'(32'h0)) begin n_fail++; $display("FAIL reset_inst got %h want 0", issue_inst); end
        n_checks++; if (issue_warp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", issue_warp_id); end
        n_checks++; if (buf_pop_enabled !== 4'b0) begin n_fail++; $display("FAIL reset_pop got %b want 0000", buf_pop_enabled); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int seq [6] = '{0, 2, 0, 2, 0, 2};
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin push(0, n); push(2, n); end
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                n_checks++; if (buf_pop_enabled !== (4'b0001 << seq[k])) begin n_fail++; $display("FAIL rr_pop k=%0d got %b want %b", k, buf_pop_enabled, 4'b0001 << seq[k]); end
            end else begin
                n_checks++; if (buf_pop_enabled !== 4'b0) begin n_fail++; $display("FAIL rr_pop_idle k=%0d got %b want 0000", k, buf_pop_enabled); end
            end
            if (k >= 1 && k <= 6) begin
                n_checks++; if (issue_valid !== 1'b1 || issue_warp_id !== 2'(seq[k-1])) begin n_fail++; $display("FAIL rr_id k=%0d got v=%b id=%0d want v=1 id=%0d", k, issue_valid, issue_warp_id, seq[k-1]); end
                n_checks++; if (issue_inst !== mk(seq[k-1], (k-1)/2)) begin n_fail++; $display("FAIL rr_inst k=%0d got %h want %h", k, issue_inst, mk(seq[k-1], (k-1)/2)); end
            end
            if (k == 7) begin
                n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got %b want 0", issue_valid); end
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_stall();
        issue_ready = 1'b0;
        push(1, 0); push(3, 0);
        #1;
        n_checks++; if (buf_pop_enabled !== 4'b1000) begin n_fail++; $display("FAIL stall_first_pop got %b want 1000", buf_pop_enabled); end
        for (int s = 0; s < 6; s++) begin
            @(negedge clk); #1;
            n_checks++; if (issue_valid !== 1'b1 || issue_warp_id !== 2'd3 || issue_inst !== mk(3, 0)) begin n_fail++; $display("FAIL stall_hold s=%0d got v=%b id=%0d inst=%h want v=1 id=3 inst=%h", s, issue_valid, issue_warp_id, issue_inst, mk(3, 0)); end
            n_checks++; if (buf_pop_enabled !== 4'b0) begin n_fail++; $display("FAIL stall_pop s=%0d got %b want 0000", s, buf_pop_enabled); end
        end
`ifdef GELATO_ISSUE_STALL_CNT_EN
        n_checks++; if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL stall_cnt got %0d want 5", stall_cycles); end
`endif
    endtask

    task automatic test_rdy_freeze();
        rdy = 1'b0; issue_ready = 1'b1;
        push(3, 1);
        for (int s = 0; s < 3; s++) begin
            #1;
            n_checks++; if (buf_pop_enabled !== 4'b0) begin n_fail++; $display("FAIL frz_pop s=%0d got %b want 0000", s, buf_pop_enabled); end
            n_checks++; if (issue_valid !== 1'b1 || issue_warp_id !== 2'd3) begin n_fail++; $display("FAIL frz_hold s=%0d got v=%b id=%0d want v=1 id=3", s, issue_valid, issue_warp_id); end
            @(negedge clk);
        end
        rdy = 1'b1; #1;
        n_checks++; if (buf_pop_enabled !== 4'b0010) begin n_fail++; $display("FAIL frz_resume_pop got %b want 0010", buf_pop_enabled); end
        @(negedge clk); #1;
        n_checks++; if (issue_warp_id !== 2'd1 || issue_inst !== mk(1, 0)) begin n_fail++; $display("FAIL frz_id1 got id=%0d inst=%h want id=1 inst=%h", issue_warp_id, issue_inst, mk(1, 0)); end
        n_checks++; if (buf_pop_enabled !== 4'b1000) begin n_fail++; $display("FAIL frz_pop3 got %b want 1000", buf_pop_enabled); end
        @(negedge clk); #1;
        n_checks++; if (issue_warp_id !== 2'd3 || issue_inst !== mk(3, 1)) begin n_fail++; $display("FAIL frz_id3 got id=%0d inst=%h want id=3 inst=%h", issue_warp_id, issue_inst, mk(3, 1)); end
`ifdef GELATO_ISSUE_STALL_CNT_EN
        n_checks++; if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL frz_stall_cnt got %0d want 5", stall_cycles); end
`endif
        @(negedge clk); #1;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL frz_drain got %b want 0", issue_valid); end
    endtask

    task automatic test_mask();
        int seq [6] = '{0, 2, 3, 0, 2, 3};
        int ns  [6] = '{3, 3, 2, 4, 4, 3};
        warp_mask = 4'b1101;
        push(0, 3); push(0, 4); push(1, 1); push(1, 2);
        push(2, 3); push(2, 4); push(3, 2); push(3, 3);
        #1;
        for (int k = 0; k < 7; k++) begin
            if (k < 6) begin
                n_checks++; if (buf_pop_enabled !== (4'b0001 << seq[k])) begin n_fail++; $display("FAIL mask_pop k=%0d got %b want %b", k, buf_pop_enabled, 4'b0001 << seq[k]); end
            end else begin
                n_checks++; if (buf_pop_enabled !== 4'b0) begin n_fail++; $display("FAIL mask_pop_idle got %b want 0000", buf_pop_enabled); end
            end
            if (k >= 1) begin
                n_checks++; if (issue_warp_id !== 2'(seq[k-1]) || issue_inst !== mk(seq[k-1], ns[k-1])) begin n_fail++; $display("FAIL mask_issue k=%0d got id=%0d inst=%h want id=%0d inst=%h", k, issue_warp_id, issue_inst, seq[k-1], mk(seq[k-1], ns[k-1])); end
            end
            @(negedge clk); #1;
        end
        n_checks++; if (4'(wr[1] - rd[1]) !== 4'd2) begin n_fail++; $display("FAIL mask_w1_untouched got %0d want 2", 4'(wr[1] - rd[1])); end
    endtask

    task automatic test_midstream_reset();
        push(2, 5); push(2, 6);
        #1;
        n_checks++; if (buf_pop_enabled !== 4'b0100) begin n_fail++; $display("FAIL mrst_pop got %b want 0100", buf_pop_enabled); end
        @(negedge clk); #1;
        n_checks++; if (issue_valid !== 1'b1 || issue_warp_id !== 2'd2) begin n_fail++; $display("FAIL mrst_pre got v=%b id=%0d want v=1 id=2", issue_valid, issue_warp_id); end
        #1; rst_n = 1'b0; #1;
        n_checks++; if (issue_valid !== 1'b0 || issue_warp_id !== 2'd0) begin n_fail++; $display("FAIL mrst_async got v=%b id=%0d want v=0 id=0", issue_valid, issue_warp_id); end
        n_checks++; if (buf_pop_enabled !== 4'b0) begin n_fail++; $display("FAIL mrst_pop_forced got %b want 0000", buf_pop_enabled); end
        @(negedge clk);
        rst_n = 1'b1; warp_mask = 4'hF;
        push(0, 10); push(3, 10);
        #1;
        n_checks++; if (buf_pop_enabled !== 4'b0001) begin n_fail++; $display("FAIL mrst_first_grant got %b want 0001", buf_pop_enabled); end
        @(negedge clk); #1;
        n_checks++; if (issue_warp_id !== 2'd0 || issue_inst !== mk(0, 10)) begin n_fail++; $display("FAIL mrst_id0 got id=%0d inst=%h want id=0 inst=%h", issue_warp_id, issue_inst, mk(0, 10)); end
        @(negedge clk); #1;
        n_checks++; if (issue_warp_id !== 2'd3 || issue_inst !== mk(3, 10)) begin n_fail++; $display("FAIL mrst_id3 got id=%0d inst=%h want id=3 inst=%h", issue_warp_id, issue_inst, mk(3, 10)); end
        @(negedge clk); #1;
    endtask

    task automatic test_single_warp();
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", issue_valid); end
        push(3, 20); push(3, 21);
        #1;
        n_checks++; if (buf_pop_enabled !== 4'b1000) begin n_fail++; $display("FAIL single_pop0 got %b want 1000", buf_pop_enabled); end
        @(negedge clk); #1;
        n_checks++; if (issue_warp_id !== 2'd3 || issue_inst !== mk(3, 20)) begin n_fail++; $display("FAIL single_a got id=%0d inst=%h want id=3 inst=%h", issue_warp_id, issue_inst, mk(3, 20)); end
        n_checks++; if (buf_pop_enabled !== 4'b1000) begin n_fail++; $display("FAIL single_pop1 got %b want 1000", buf_pop_enabled); end
        @(negedge clk); #1;
        n_checks++; if (issue_valid !== 1'b1 || issue_inst !== mk(3, 21)) begin n_fail++; $display("FAIL single_b got v=%b inst=%h want v=1 inst=%h", issue_valid, issue_inst, mk(3, 21)); end
        n_checks++; if (buf_pop_enabled !== 4'b0) begin n_fail++; $display("FAIL single_pop2 got %b want 0000", buf_pop_enabled); end
        @(negedge clk); #1;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", issue_valid); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_rdy_freeze();
        test_mask();
        test_midstream_reset();
        test_single_warp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gelato_warp_inst_issuer.md
Name: gelato_warp_inst_issuer

Overview:
- Consumer (pop) side of the per-warp instruction buffers. Each buffer is fed by the decoder.
- Arbitrates round-robin among NUM_WARPS non-empty buffers and pops the head instruction of the winner.
- Presents that instruction to the issue/operand-collect stage through a registered valid/ready output.
- Sits between the warp instruction buffers and the issue pipeline.

Parameters:
- NUM_WARPS, 4, number of warp instruction buffers served (power of two, 2..32).
- WARP_ID_WIDTH, $clog2(NUM_WARPS), width of warp index.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- rdy  input  1  global enable; when low all state holds
- buf_empty  input  NUM_WARPS  per-warp buffer empty flag
- buf_tail_data  input  NUM_WARPS x inst_t  per-warp head-of-queue instruction, valid when !buf_empty[w]
- buf_pop_enabled  output  NUM_WARPS  one-hot pop strobe, combinational; buffer dequeues on the clock edge
- issue_valid  output  1  registered instruction valid
- issue_inst  output  inst_t  registered instruction
- issue_warp_id  output  WARP_ID_WIDTH  warp that owns issue_inst
- issue_ready  input  1  downstream accepts when issue_valid && issue_ready
- warp_mask  input  NUM_WARPS  1 = warp eligible; masked warps are never popped
- stall_cycles  output  32  only with GELATO_ISSUE_STALL_CNT_EN

Behaviour:
- Reset, clk and rst_n: asynchronous, active-low. Reset values:
  - issue_valid=0, issue_inst=0, issue_warp_id=0.
  - rr_ptr=0.
  - buf_pop_enabled=0 (combinationally forced while rst_n=0).
- Eligibility: elig[w] = !buf_empty[w] && warp_mask[w].
- Slot free: slot_free = !issue_valid || issue_ready.
- Grant:
  - When rdy && slot_free && |elig, grant the first eligible warp at or after rr_ptr, in increasing index with wrap from NUM_WARPS-1 to 0.
  - buf_pop_enabled = onehot(grant) in the same cycle, otherwise all zero.
  - At most one bit is set per cycle.
- Capture on the clock edge with a grant:
  - issue_inst <= buf_tail_data[grant]
  - issue_warp_id <= grant
  - issue_valid <= 1
  - rr_ptr <= grant+1, wrapping modulo NUM_WARPS
- Pop-to-valid latency: 1 cycle. Sustained throughput: 1 instruction per cycle when issue_ready is held high.
- Rdy, slot_free, eligibility and handshake:
  - Accept with no grant (issue_valid && issue_ready && no eligible warp): issue_valid <= 0.
  - Stall (issue_valid && !issue_ready): issue_valid, issue_inst and issue_warp_id hold, and no pop occurs.
  - Simultaneous accept and new grant: back-to-back; issue_valid stays 1 and the new instruction is loaded.
  - rdy=0: no pop, registers hold, rr_ptr holds, and issue_ready is ignored. A pending instruction is not consumed.
  - All buffers empty or masked: no pop, rr_ptr unchanged.
- Mask and empty timing:
  - warp_mask changes take effect in the same cycle.
  - An already-captured instruction is not revoked by a later mask change.
  - A buffer becoming non-empty is eligible in the same cycle its empty flag drops.
- Mid-operation reset: the in-flight instruction is discarded and issue_valid drops immediately. Buffers are reset by the same rst_n.
- Single-warp fairness: a sole eligible warp is granted every free cycle regardless of rr_ptr.

Optional Feature:
- Macro: GELATO_ISSUE_STALL_CNT_EN.
- Defined:
  - stall_cycles port exists.
  - 32-bit counter increments each rdy cycle with issue_valid && !issue_ready.
  - Saturates at 0xFFFFFFFF. Reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- gelato_types package owns inst_t (already shared with the instruction buffer and decoder).
- `NUM_WARPS default lives in gelato_macros.svh.
- One sub-module: gelato_rr_arbiter, with parameter N and ports:
  - req[N], ptr[$clog2(N)] inputs
  - grant_valid, grant_idx, grant_onehot outputs
  - purely combinational
- rr_ptr and the output register stay in the issuer.

Test Plan:
- Reset then fill warps 0 and 2 with 3 instructions each, issue_ready=1 -> issue_warp_id sequence 0,2,0,2,0,2 on consecutive cycles; one pop per cycle; pop strobe 1 cycle before each valid.
- issue_valid=1 with issue_ready=0 for 5 cycles -> issue_inst and issue_warp_id stable, buf_pop_enabled=0 all 5 cycles. With GELATO_ISSUE_STALL_CNT_EN, stall_cycles=5.
- rdy=0 for 3 cycles while warps 1 and 3 are non-empty and issue_ready=1 -> no pops, outputs and rr_ptr frozen. The first grant after rdy=1 matches the pre-freeze order.
- warp_mask=4'b1101 with all buffers non-empty -> warp 1 never popped; order is 0,2,3,0,...
- Only warp 3 non-empty, with rr_ptr=0 -> warp 3 granted; rr_ptr wraps to 0; a second warp-3 instruction is issued the next cycle.
- Assert rst_n=0 mid-stream while issue_valid=1 -> issue_valid=0 and buf_pop_enabled=0 asynchronously. After release the first grant starts from warp 0.
